series_cal: RTL and testbench

- Parametrised Taylor-series evaluator. Computes cosh(x) or sinh(x) of a signed fixed-point input. Controller and datapath are merged into one block.
- Successor to the fixed 16-bit cosh calculator. Adds the following:
  - width, fraction and term-count parameters;
  - runtime cosh/sinh mode select;
  - signed input;
  - result saturation;
  - a start/busy/ready handshake.

---
 rtl/series_cal_if.sv | 13 +
 rtl/series_cal.sv | 119 +++++++++++
 tb/tb_series_cal.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/series_cal_if.sv
// Request/result bundle for series_cal: operand and mode in, saturated result plus status out.
interface series_cal_if #(parameter int W = 16);
  logic         start;
  logic         mode;
  logic [W-1:0] inX;
  logic [W:0]   result;
  logic         busy;
  logic         ready;
  logic [3:0]   term_idx;

  modport master (output start, mode, inX, input result, busy, ready, term_idx);
  modport slave  (input start, mode, inX, output result, busy, ready, term_idx);
endinterface

// File: rtl/series_cal.sv
// Taylor-series cosh/sinh of a signed fixed-point operand; result valid 2*TERMS+1 cycles after start.
// Starts arriving while a computation is in flight are dropped, so the requester must wait for ready.
module series_cal #(
  parameter int W     = 16,
  parameter int FRAC  = 14,
  parameter int TERMS = 8
) (
  input  logic        clock,
  input  logic        reset,
  series_cal_if.slave bus
);
  localparam int PW = 2*W + FRAC + 8;
  localparam logic [3:0] K_LAST = 4'(TERMS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ACC, POW, DONE} state_t;

  state_t                r_state, w_next;
  logic signed [W-1:0]   r_x;
  logic                  r_m;
  logic signed [W+1:0]   r_x2, r_pow;
  logic signed [W+3:0]   r_acc;
  logic [3:0]            r_k;
  logic [W:0]            r_result;

  // round(2^FRAC / n!) half up; successive floor divisions equal one floor division by n!.
  function automatic logic [63:0] coef_f(input int n);
    logic [63:0] q;
    q = 64'd1 << (FRAC + 1);
    for (int i = 2; i <= n; i++) q = q / 64'(i);
    return (q + 64'd1) >> 1;
  endfunction

  logic [FRAC:0] w_rom [2][16];
  for (genvar g = 0; g < 16; g++) begin : g_rom
    localparam logic [63:0] C0 = coef_f(2*g);
    localparam logic [63:0] C1 = coef_f(2*g + 1);
    assign w_rom[0][g] = C0[FRAC:0];
    assign w_rom[1][g] = C1[FRAC:0];
  end

  logic [FRAC:0]         w_coef;
  logic signed [PW-1:0]  w_xe, w_powe, w_x2e, w_coefe, w_sq, w_pp, w_pc;
  logic signed [W+3:0]   w_sum;
  logic [W:0]            w_sat;
  logic                  w_unused;

  assign w_coef  = w_rom[r_m][r_k];
  assign w_xe    = {{(PW-W){r_x[W-1]}}, r_x};
  assign w_powe  = {{(PW-W-2){r_pow[W+1]}}, r_pow};
  assign w_x2e   = {{(PW-W-2){r_x2[W+1]}}, r_x2};
  assign w_coefe = {{(PW-FRAC-1){1'b0}}, w_coef};
  assign w_sq    = w_xe * w_xe;
  assign w_pp    = w_powe * w_x2e;
  assign w_pc    = w_powe * w_coefe;
  // Slicing at FRAC is the arithmetic shift followed by truncation to the register width.
  assign w_sum   = r_acc + w_pc[FRAC +: W+4];
  assign w_unused = ^{w_sq[FRAC-1:0], w_sq[PW-1:FRAC+W+2], w_pp[FRAC-1:0],
                      w_pp[PW-1:FRAC+W+2], w_pc[FRAC-1:0], w_pc[PW-1:FRAC+W+4]};

  always_comb begin
    w_sat = w_sum[W:0];
    if (w_sum[W+3:W] != 4'b0000 && w_sum[W+3:W] != 4'b1111)
      w_sat = w_sum[W+3] ? {1'b1, {W{1'b0}}} : {1'b0, {W{1'b1}}};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = LOAD;
      LOAD:    w_next = ACC;
      ACC:     w_next = (r_k == K_LAST) ? DONE : POW;
      POW:     w_next = ACC;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_m      <= 1'b0;
      r_x2     <= '0;
      r_pow    <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (bus.start) begin
          r_x <= $signed(bus.inX);
          r_m <= bus.mode;
        end
        LOAD: begin
          r_x2  <= w_sq[FRAC +: W+2];
          r_pow <= r_m ? {{2{r_x[W-1]}}, r_x} : (W+2)'(1) << FRAC;
          r_acc <= '0;
          r_k   <= '0;
        end
        ACC: begin
          r_acc <= w_sum;
          // Capture on the final term so the result is already stable while ready is high.
          if (r_k == K_LAST) r_result <= w_sat;
        end
        POW: begin
          r_pow <= w_pp[FRAC +: W+2];
          r_k   <= r_k + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = r_result;
  assign bus.busy     = (r_state == LOAD) || (r_state == ACC) || (r_state == POW);
  assign bus.ready    = (r_state == DONE);
  assign bus.term_idx = r_k;
endmodule

// File: tb/tb_series_cal.sv
// Bench for series_cal: default instance (W=16,FRAC=14,TERMS=8) and a TERMS=1 instance (W=12,FRAC=10).
module tb_series_cal;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  series_cal_if #(.W(16)) bus_a ();
  series_cal_if #(.W(12)) bus_b ();

  series_cal dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  series_cal #(.W(12), .FRAC(10), .TERMS(1)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  typedef struct { int exp; int tol; } sb_t;
  sb_t qa[$];
  sb_t qb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp, input int tol);
    int d;
    d = got - exp;
    if (d < 0) d = -d;
    total++;
    assert (d <= tol) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  always @(negedge clock) begin
    if (reset && bus_a.ready) begin
      total++;
      assert (qa.size() > 0) else begin
        bad++;
        $error("FAIL a_unexpected_ready got=ready want=no_ready");
      end
      if (qa.size() > 0) begin
        sb_t e;
        int d;
        e = qa.pop_front();
        d = int'($signed(bus_a.result)) - e.exp;
        if (d < 0) d = -d;
        total++;
        assert (d <= e.tol) else begin
          bad++;
          $error("FAIL a_result got=%0d want=%0d tol=%0d", $signed(bus_a.result), e.exp, e.tol);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset && bus_b.ready) begin
      total++;
      assert (qb.size() > 0) else begin
        bad++;
        $error("FAIL b_unexpected_ready got=ready want=no_ready");
      end
      if (qb.size() > 0) begin
        sb_t e;
        int d;
        e = qb.pop_front();
        d = int'($signed(bus_b.result)) - e.exp;
        if (d < 0) d = -d;
        total++;
        assert (d <= e.tol) else begin
          bad++;
          $error("FAIL b_result got=%0d want=%0d tol=%0d", $signed(bus_b.result), e.exp, e.tol);
        end
      end
    end
  end

  // One request; returns cycles from the accepting edge to ready (0 on timeout), busy cycles, k at ready.
  task automatic run(input bit sel, input bit m, input int x, input int exp, input int tol,
                     input bit inject, output int lat, output int busy_n, output int k_rdy);
    @(negedge clock);
    if (sel) begin
      bus_b.start = 1'b1; bus_b.mode = m; bus_b.inX = 12'(x);
      qb.push_back('{exp, tol});
    end else begin
      bus_a.start = 1'b1; bus_a.mode = m; bus_a.inX = 16'(x);
      qa.push_back('{exp, tol});
    end
    @(posedge clock);
    lat = 0; busy_n = 0; k_rdy = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      if (inject && (n == 3 || n == 10)) begin
        bus_a.start = 1'b1;
        bus_a.mode  = ~m;
        bus_a.inX   = 16'(-x - 4096 * n);
      end
      if (sel ? bus_b.busy : bus_a.busy) busy_n++;
      if (sel ? bus_b.ready : bus_a.ready) begin
        lat = n;
        k_rdy = int'(sel ? bus_b.term_idx : bus_a.term_idx);
        break;
      end
    end
  endtask

  initial begin
    int lat, bn, tk;
    bus_a.start = 1'b0; bus_a.mode = 1'b0; bus_a.inX = '0;
    bus_b.start = 1'b0; bus_b.mode = 1'b0; bus_b.inX = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_busy",   int'(bus_a.busy),     0, 0);
    chk("rst_ready",  int'(bus_a.ready),    0, 0);
    chk("rst_result", int'(bus_a.result),   0, 0);
    chk("rst_k",      int'(bus_a.term_idx), 0, 0);
    chk("rst_b_result", int'(bus_b.result), 0, 0);
    chk("rst_b_busy",   int'(bus_b.busy),   0, 0);

    run(0, 0, 0, 16384, 0, 0, lat, bn, tk);
    chk("cosh0_latency", lat, 17, 0);
    chk("cosh0_busy_cycles", bn, 16, 0);
    chk("cosh0_k_at_ready", tk, 7, 0);

    run(0, 0, 16384, 25282, 4, 0, lat, bn, tk);
    chk("cosh1_latency", lat, 17, 0);
    run(0, 1, 16384, 19254, 4, 0, lat, bn, tk);
    chk("sinh1_latency", lat, 17, 0);
    run(0, 1, -16384, -19254, 4, 0, lat, bn, tk);
    chk("sinhm1_latency", lat, 17, 0);
    run(0, 1, 0, 0, 0, 0, lat, bn, tk);
    chk("sinh0_latency", lat, 17, 0);

    run(0, 0, 16384, 25282, 4, 1, lat, bn, tk);
    chk("ignore_start_latency", lat, 17, 0);
    chk("ignore_start_busy", bn, 16, 0);

    @(negedge clock);
    bus_a.start = 1'b1; bus_a.mode = 1'b0; bus_a.inX = 16'sd16384;
    @(posedge clock);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      bus_a.start = 1'b0;
      if (n == 6) reset = 1'b0;
    end
    @(negedge clock);
    chk("midrst_busy",   int'(bus_a.busy),     0, 0);
    chk("midrst_ready",  int'(bus_a.ready),    0, 0);
    chk("midrst_result", int'(bus_a.result),   0, 0);
    chk("midrst_k",      int'(bus_a.term_idx), 0, 0);
    reset = 1'b1;
    bn = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus_a.busy) bn++;
    end
    chk("midrst_stays_idle", bn, 0, 0);

    run(0, 1, 16384, 19254, 4, 0, lat, bn, tk);
    chk("after_rst_latency", lat, 17, 0);

    run(1, 0, 1024, 1024, 0, 0, lat, bn, tk);
    chk("t1_cosh_latency", lat, 3, 0);
    chk("t1_cosh_busy_cycles", bn, 2, 0);
    chk("t1_cosh_k_at_ready", tk, 0, 0);
    run(1, 1, 1024, 1024, 0, 0, lat, bn, tk);
    chk("t1_sinh_latency", lat, 3, 0);

    repeat (5) @(negedge clock);
    chk("sb_a_drained", qa.size(), 0, 0);
    chk("sb_b_drained", qb.size(), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
